// File: rtl/dvi_timing_pkg.sv
// Default DVI raster timing (1024x600) and coordinate-width helpers shared by the
// timing generator and its phase sub-block.
package dvi_timing_pkg;

    localparam int unsigned DEF_SER      = 7;
    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FP     = 6;
    localparam int unsigned DEF_H_SYNC   = 20;
    localparam int unsigned DEF_H_BP     = 142;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 4;
    localparam int unsigned DEF_V_SYNC   = 1;
    localparam int unsigned DEF_V_BP     = 96;
    localparam int unsigned DEF_FRAME_W  = 11;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned HS_SHIFT_W   = 4;
    localparam int unsigned HS_SHIFT_MAX = (1 << HS_SHIFT_W) - 1;

    // Bits needed to hold a coordinate in 0..total-1, never less than one.
    function automatic int unsigned coord_w(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/dvi_phase_gen.sv
// Bit-slot phase counter for the serializer: one-hot slot strobe, pixel clock and
// last-slot strobe, all held while enable is low.
module dvi_phase_gen #(
    parameter int unsigned SER = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    output logic [$clog2(SER)-1:0] phase,
    output logic [SER-1:0]         inPix,
    output logic                   CL,
    output logic                   pix_stb
);

    localparam int unsigned PW      = $clog2(SER);
    localparam int unsigned CL_HIGH = (SER + 1) / 2;

    if (SER < 2 || SER > 10) begin : g_ser_check
        $error("dvi_phase_gen: SER must be in 2..10");
    end

    logic [PW-1:0] phase_nxt_c;

    always_comb begin
        phase_nxt_c = (phase == PW'(SER - 1)) ? '0 : phase + PW'(1);
    end

    // Outputs are registered from the next phase so they always describe the current slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            inPix   <= SER'(1);
            CL      <= 1'b1;
            pix_stb <= 1'b0;
        end else if (enable) begin
            phase   <= phase_nxt_c;
            inPix   <= SER'(1) << phase_nxt_c;
            CL      <= (32'(phase_nxt_c) < CL_HIGH);
            pix_stb <= (phase_nxt_c == PW'(SER - 1));
        end
    end

endmodule

// File: rtl/dvi_timing_gen.sv
// DVI raster timing generator: pixel/line/frame counters with registered DE, HS, VS
// and line/frame start pulses, all decoded one pixel behind the coordinates.
module dvi_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int unsigned SER      = DEF_SER,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [HS_SHIFT_W-1:0] hs_shift,
    output logic                  CL,
    output logic [SER-1:0]        inPix,
    output logic                  pix_stb,
    output logic                  HS,
    output logic                  VS,
    output logic                  DE,
    output logic [coord_w(H_ACTIVE + H_FP + H_SYNC + H_BP)-1:0] X,
    output logic [coord_w(V_ACTIVE + V_FP + V_SYNC + V_BP)-1:0] Y,
    output logic [FRAME_W-1:0]    frame,
    output logic                  line_start,
    output logic                  frame_start
);

    localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW          = coord_w(LINE_LEN);
    localparam int unsigned YW          = coord_w(FRAME_LINES);
    localparam int unsigned PW          = $clog2(SER);
    localparam int unsigned HS_BASE     = H_ACTIVE + H_FP;
    localparam int unsigned VS_FIRST    = V_ACTIVE + V_FP;

    if (SER < 2 || H_SYNC == 0 || HS_BASE + HS_SHIFT_MAX + H_SYNC > LINE_LEN) begin : g_param_check
        $error("dvi_timing_gen: illegal SER or horizontal timing parameters");
    end

    logic [PW-1:0]         phase;
    logic [HS_SHIFT_W-1:0] hs_lat;
    logic                  pix_adv_c;
    logic                  x_wrap_c;
    logic                  y_wrap_c;
    logic                  origin_c;
    logic                  de_c;
    logic                  hs_act_c;
    logic                  vs_act_c;
    int unsigned           hs_first_c;
    int unsigned           hs_last_c;

    dvi_phase_gen #(
        .SER(SER)
    ) u_phase (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .phase  (phase),
        .inPix  (inPix),
        .CL     (CL),
        .pix_stb(pix_stb)
    );

    // Decode from the current (pre-update) coordinates; HS window clamped to the line end.
    always_comb begin
        pix_adv_c  = enable && (phase == PW'(SER - 1));
        x_wrap_c   = (X == XW'(LINE_LEN - 1));
        y_wrap_c   = (Y == YW'(FRAME_LINES - 1));
        origin_c   = (X == '0) && (Y == '0);
        de_c       = (32'(X) < H_ACTIVE) && (32'(Y) < V_ACTIVE);
        hs_first_c = HS_BASE + 32'(hs_lat);
        hs_last_c  = hs_first_c + H_SYNC - 1;
        if (hs_last_c > LINE_LEN - 1) begin
            hs_last_c = LINE_LEN - 1;
        end
        hs_act_c   = (32'(X) >= hs_first_c) && (32'(X) <= hs_last_c);
        vs_act_c   = (32'(Y) >= VS_FIRST) && (32'(Y) < VS_FIRST + V_SYNC);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            X           <= '0;
            Y           <= '0;
            frame       <= '0;
            hs_lat      <= '0;
            DE          <= 1'b0;
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_adv_c) begin
            X <= x_wrap_c ? '0 : X + XW'(1);
            if (x_wrap_c) begin
                Y <= y_wrap_c ? '0 : Y + YW'(1);
                if (y_wrap_c) begin
                    frame <= frame + FRAME_W'(1);
                end
            end
            // HS offset only changes at the frame origin so a frame never mixes offsets.
            if (origin_c) begin
                hs_lat <= hs_shift;
            end
            DE          <= de_c;
            HS          <= hs_act_c ? HS_POL : ~HS_POL;
            VS          <= vs_act_c ? VS_POL : ~VS_POL;
            line_start  <= (X == '0);
            frame_start <= origin_c;
        end
    end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Randomized scoreboard bench for dvi_timing_gen on a reduced raster, using a
// pixel-index reference model.
module tb_dvi_timing_gen;

    localparam int SER   = 7;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HSY   = 3;
    localparam int HBP   = 16;
    localparam int VA    = 6;
    localparam int VFP   = 1;
    localparam int VSY   = 1;
    localparam int VBP   = 2;
    localparam int HT    = HA + HFP + HSY + HBP;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FW    = 3;
    localparam int XW    = $clog2(HT);
    localparam int YW    = $clog2(VT);
    localparam int CL_HI = (SER + 1) / 2;
    localparam bit HSP   = 1'b1;
    localparam bit VSP   = 1'b0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [3:0]    hs_shift = 4'd0;
    logic          CL;
    logic [SER-1:0] inPix;
    logic          pix_stb;
    logic          HS;
    logic          VS;
    logic          DE;
    logic [XW-1:0] X;
    logic [YW-1:0] Y;
    logic [FW-1:0] frame;
    logic          line_start;
    logic          frame_start;

    dvi_timing_gen #(
        .SER(SER), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .FRAME_W(FW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .hs_shift   (hs_shift),
        .CL         (CL),
        .inPix      (inPix),
        .pix_stb    (pix_stb),
        .HS         (HS),
        .VS         (VS),
        .DE         (DE),
        .X          (X),
        .Y          (Y),
        .frame      (frame),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } dec_t;

    dec_t           exp_q[$];
    dec_t           mon_e;
    logic [SER-1:0] exp_oh;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             m_pix    = 0;
    int             m_slot   = 0;
    int             m_lat    = 0;
    bit             adv_seen = 1'b0;
    int             pix_cnt  = 0;
    int             de_cnt   = 0;
    int             fs_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_phase"}, 32'({inPix, CL, pix_stb}), 32'({SER'(1), 1'b1, 1'b0}));
        check({tag, "_xyf"}, 32'({X, Y, frame}), 32'd0);
        check({tag, "_sync"}, 32'({DE, HS, VS, line_start, frame_start}),
              32'({1'b0, !HSP, !VSP, 2'b00}));
    endtask

    // Expected decode for the pixel with running index m_pix, from raster arithmetic.
    task automatic push_pixel();
        int   x;
        int   y;
        dec_t e;
        x = m_pix % HT;
        y = (m_pix / HT) % VT;
        if (x == 0 && y == 0) m_lat = int'(hs_shift);
        e.de = (x < HA) && (y < VA);
        e.hs = ((x >= HA + HFP + m_lat) && (x < HA + HFP + m_lat + HSY) && (x < HT)) ? HSP : !HSP;
        e.vs = ((y >= VA + VFP) && (y < VA + VFP + VSY)) ? VSP : !VSP;
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
        exp_q.push_back(e);
        m_pix++;
    endtask

    task automatic tick(input bit en);
        enable = en;
        @(posedge clock);
        #1;
        if (en) begin
            if (m_slot == SER - 1) begin
                push_pixel();
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
    endtask

    // Monitor: state checked every cycle, decoded outputs popped on each pixel advance.
    always @(negedge clock) begin
        if (reset) begin
            adv_seen = 1'b0;
        end else begin
            check("xy_frame", 32'({X, Y, frame}),
                  32'({XW'(m_pix % HT), YW'((m_pix / HT) % VT), FW'((m_pix / (HT * VT)) % (1 << FW))}));
            exp_oh = '0;
            exp_oh[m_slot] = 1'b1;
            check("phase", 32'({inPix, CL, pix_stb}),
                  32'({exp_oh, 1'(m_slot < CL_HI), 1'(m_slot == SER - 1)}));
            if (adv_seen) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard: pixel advance with no expected entry at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("decode", 32'({DE, HS, VS, line_start, frame_start}), 32'(mon_e));
                    pix_cnt++;
                    de_cnt += int'(DE);
                    fs_cnt += int'(frame_start);
                end
            end
            adv_seen = pix_stb && enable;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("por");
        reset = 1'b0;

        // One full frame, continuous enable; hs_shift changes mid-frame for the next frame.
        for (int i = 0; i < HT * VT * SER; i++) begin
            if (m_pix == HT * VT / 2) hs_shift = 4'd5;
            tick(1'b1);
        end
        @(negedge clock);
        #1;
        check("frame_pixels", 32'(pix_cnt), 32'(HT * VT));
        check("frame_de", 32'(de_cnt), 32'(HA * VA));
        check("frame_starts", 32'(fs_cnt), 32'd1);
        check("frame_one", 32'(frame), 32'd1);

        // Random enable gaps and random hs_shift updates.
        for (int i = 0; i < 3 * HT * VT * SER; i++) begin
            if ($urandom_range(0, 99) < 2) hs_shift = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 7) != 0);
        end

        // Long hold at X=20, phase 3, then resume into phase 4.
        for (int i = 0; i < 4 * HT * SER && !((m_pix % HT) == 20 && m_slot == 3); i++) tick(1'b1);
        check("hold_x", 32'(X), 32'd20);
        repeat (50) tick(1'b0);
        tick(1'b1);
        check("resume_phase", 32'(inPix), 32'd1 << 4);

        // Run up to the frame-counter wrap (2^FW - 1 -> 0).
        for (int i = 0; i < 60000 && m_pix < (1 << FW) * HT * VT; i++) begin
            if ($urandom_range(0, 99) < 2) hs_shift = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 7) != 0);
        end
        check("frame_wrap", 32'({frame, X, Y}), 32'd0);
        hs_shift = 4'd15;

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 4 * HT * VT * SER && !((m_pix % HT) == 25 && ((m_pix / HT) % VT) == 4); i++) tick(1'b1);
        #1 reset = 1'b1;
        #1 check_reset_vals("async");
        exp_q.delete();
        m_pix  = 0;
        m_slot = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < HT * VT * SER + 200; i++) begin
            if ($urandom_range(0, 99) < 2) hs_shift = 4'($urandom_range(0, 15));
            tick($urandom_range(0, 5) != 0);
        end
        @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 Parameter SER, default 7: bit-clock cycles per pixel; legal range 2..10.
REQ-002 Parameter H_ACTIVE, default 1024: active pixels per line.
REQ-003 Parameter H_FP / H_SYNC / H_BP, defaults 6 / 20 / 142: horizontal porches and sync in pixels; H_TOTAL = sum of the four horizontal parameters = 1192.
REQ-004 Parameter V_ACTIVE, default 600: active lines per frame.
REQ-005 Parameter V_FP / V_SYNC / V_BP, defaults 4 / 1 / 96: vertical porches and sync in lines; V_TOTAL = 701.
REQ-006 Parameter HS_POL / VS_POL, default 0 / 0: sync active level.
REQ-007 Parameter FRAME_W, default 11: frame counter width.
REQ-008 clock  in  1: serial bit clock, 255 MHz nominal.
REQ-009 reset  in  1: asynchronous, active-high reset.
REQ-010 enable  in  1: run/hold control.
REQ-011 hs_shift  in  4: HS start offset in pixels; sampled only at frame start.
REQ-012 CL  out  1: pixel clock for the serializer.
REQ-013 inPix  out  SER: one-hot bit-slot strobe; bit k is high during slot k.
REQ-014 pix_stb  out  1: high on the last slot (SER-1) of each pixel.
REQ-015 HS / VS / DE  out  1 each: registered sync and data-enable signals.
REQ-016 X  out  clog2(H_TOTAL) / Y  out  clog2(V_TOTAL): current pixel coordinates.
REQ-017 frame  out  FRAME_W: frame count.
REQ-018 line_start / frame_start  out  1 each: one-pixel pulses.

Function
REQ-019 The phase counter shall count 0..SER-1 and wrap, advancing only while enable=1.
REQ-020 inPix shall equal the one-hot encoding of phase, registered.
REQ-021 CL shall be 1 while phase is below (SER+1)/2 and 0 otherwise; with SER=7 it is high 4 slots and low 3.
REQ-022 All pixel-rate state (X, Y, frame, DE, HS, VS, line_start, frame_start) shall update only on cycles where enable=1 and phase=SER-1.
REQ-023 X shall increment each pixel and wrap H_TOTAL-1 -> 0.
REQ-024 When X wraps, Y shall increment, wrapping V_TOTAL-1 -> 0.
REQ-025 When Y wraps, frame shall increment, wrapping modulo 2^FRAME_W with no saturation.
REQ-026 DE, HS and VS shall be decoded from the pre-update X and Y, giving one pixel of latency.
REQ-027 DE = (X < H_ACTIVE) and (Y < V_ACTIVE).
REQ-028 HS shall be active for H_SYNC pixels starting at X = H_ACTIVE + H_FP + hs_lat.
REQ-029 hs_lat is hs_shift latched when X=0 and Y=0; mid-frame changes to hs_shift have no effect.
REQ-030 The HS window shall be clamped so it ends at or before H_TOTAL-1; it never wraps into the next line.
REQ-031 VS shall be active for V_SYNC full lines starting at Y = V_ACTIVE + V_FP, transitioning at X=0 only.
REQ-032 line_start shall be 1 for the pixel where X=0.
REQ-033 frame_start shall be 1 for the pixel where X=0 and Y=0.
REQ-034 When enable=0, all outputs shall hold their values, including CL and inPix.
REQ-035 Deasserting enable mid-line shall lose no pixel; counting resumes at the held phase.
REQ-036 A wrap of X, Y and frame on the same pixel shall perform all three updates in that same cycle.

Reset
REQ-037 While reset=1, the block shall force: phase=0, inPix=1 (bit 0), CL=1, pix_stb=0, X=0, Y=0, frame=0, DE=0, HS=~HS_POL, VS=~VS_POL, line_start=0, frame_start=0, hs_lat=0.
REQ-038 Reset asserted mid-frame shall take effect immediately (asynchronously); the first pixel after release shall be X=0, Y=0.
REQ-039 Release of reset shall be synchronised externally; the block shall not contain a reset synchroniser.

Structure
REQ-040 Package dvi_timing_pkg shall hold the default timing constants, the derived totals H_TOTAL/V_TOTAL, and the coordinate-width helpers.
REQ-041 Sub-module dvi_phase_gen shall hold the phase counter, inPix, CL and pix_stb, parameterised by SER.
REQ-042 The top level shall hold the X/Y/frame counters and the sync decode.
REQ-043 Elaboration shall fail when SER < 2, H_SYNC = 0, or H_ACTIVE + H_FP + 15 + H_SYNC > H_TOTAL.

Verification
REQ-044 Default parameters, enable=1, 30 clocks after reset -> inPix cycles 0000001..1000000 with period 7; CL period 7, high 4; pix_stb once per 7 clocks.
REQ-045 Run one full frame -> exactly 1192x701 pix_stb pulses; 614400 DE pixels; frame 0->1; frame_start pulses once.
REQ-046 hs_shift=0 then 5 -> HS active at X=1030..1049 on every line; hs_shift changed to 5 mid-frame -> takes effect on the next frame only, HS at X=1035..1054.
REQ-047 VS check -> VS active (0) for exactly line Y=604, covering X=0..1191; HS_POL=1 build -> HS polarity inverted.
REQ-048 Hold enable low for 50 clocks at X=500, phase=3 -> all outputs frozen; on resume, phase 4 follows and no pixel is skipped.
REQ-049 Assert reset at X=800, Y=300 -> outputs reach reset values within the same cycle; after release, first pixel is X=0, Y=0, frame=0; frame counter at 2047 -> wraps to 0.
